audio_note_detector: RTL and testbench
======================================

// Module: audio_note_detector
// PURPOSE
//  Input-side counterpart of the square-wave tone generator. Drains samples from the Audio_Controller input FIFO
//  (audio_in_available/read_audio_in), measures waveform period by hysteretic rising zero-crossings, and decodes it
//  to one of seven notes C..B. note_onehot uses the SW/key_currently_pressed bit order; feeds the learn-song compare.
// PARAMETERS
//  HYST       32'd4000000  signed crossing threshold; rise above +HYST, fall below -HYST
//  PER_C..B   192000,172000,152000,143000,128000,114000,102000  nominal full periods, CLOCK_50 cycles
//  TOL_SHIFT  5            match window = PER_x +/- (PER_x >> TOL_SHIFT)
//  STABLE_N   3            consecutive matching periods before a note is reported (1..15)
//  TIMEOUT    400000       cycles without a rising crossing => silence
// PORTS
//  CLOCK_50                in   1   system clock, 50 MHz
//  reset                   in   1   asynchronous, active-high
//  audio_in_available      in   1   input FIFO holds a sample
//  left_channel_audio_in   in   32  signed sample, valid while available
//  right_channel_audio_in  in   32  signed sample, used only with stereo option
//  read_audio_in           out  1   one-cycle pop strobe to FIFO
//  note_onehot             out  7   bit6=C,5=D,4=E,3=F,2=G,1=A,0=B; all-zero = no note
//  note_valid              out  1   high when note_onehot is nonzero
//  period_cycles           out  32  last measured period, unsigned
// BEHAVIOUR
//  Reset (async): read_audio_in=0, note_onehot=0, note_valid=0, period_cycles=0, cnt=0, match_cnt=0,
//    crossing state BELOW, armed=0. Reset mid-measurement discards the partial period.
//  Read handshake: if audio_in_available=1 and read_audio_in=0, assert read_audio_in for one cycle and load
//    sample register that cycle. Never back-to-back; available held high gives 1,0,1,0 pulsing.
//  Sample evaluated the cycle after capture. Comparisons are signed 32-bit.
//  Period counter cnt: +1 every cycle, saturates at TIMEOUT.
//  Crossing FSM: BELOW -> ABOVE when sample > +HYST (rising event); ABOVE -> BELOW when sample < -HYST.
//    Samples inside the band do not change state.
//  Rising event, armed=0: cnt<=0, armed<=1, no evaluation (first edge after reset/silence).
//  Rising event, armed=1: period_cycles<=cnt, cnt<=0, evaluate cnt. Candidate = lowest bit index-from-C whose
//    window contains cnt. Window edges inclusive; overlaps resolved by C>D>...>B priority.
//  Evaluate: no candidate -> match_cnt<=0, note outputs cleared.
//    Candidate == prev_candidate -> match_cnt++ (saturate at STABLE_N).
//    Otherwise -> prev_candidate<=candidate, match_cnt<=1, note outputs cleared.
//  Outputs update the cycle after the evaluating event. note_onehot=onehot(prev_candidate) iff
//    match_cnt>=STABLE_N, else 0. From silence, first report follows STABLE_N+1 rising edges.
//  Timeout (cnt==TIMEOUT): note outputs cleared, match_cnt<=0, armed<=0. Timeout and rising event in the
//    same cycle: timeout applies, and the event acts as the arming edge (cnt<=0, armed<=1).
// CONFIGURATION
//  NOTE_DETECT_STEREO_EN defined: sample = (left + right) >>> 1, using a 33-bit signed sum, no overflow.
//  Undefined: sample = left only; right port ignored.
//  Handshake and timing identical in both builds.
// TESTING
//  1 available pulsed every 1042 cycles, +/-1e8 square, half-period 96000 -> note_onehot=7'b1000000 after the
//    4th rising edge, period_cycles within +/-1042 of 192000.
//  2 Continue test 1 then switch to half-period 51000 -> outputs 0 after first B period;
//    7'b0000001 after 3 B periods.
//  3 +/-1e6 square (inside HYST) -> note_valid never asserts; read_audio_in pulses once per available.
//  4 audio_in_available held high 20 cycles -> read_audio_in = 1,0,1,0...; exactly 10 pops.
//  5 Lock on E, then constant 0 samples -> note cleared exactly TIMEOUT cycles after last rising edge;
//    next lock needs 4 edges.
//  6 reset pulsed mid-period while locked on G -> outputs 0 asynchronously; relock after 4 edges.
//    With NOTE_DETECT_STEREO_EN, L=+1e8, R=-1e8 -> no crossings, no note.

Source files
------------

// File: rtl/audio_note_detector.sv
// Audio note detector: pops samples from the codec input FIFO, times hysteretic rising zero-crossings
// and decodes the period to one of seven notes C..B. Define NOTE_DETECT_STEREO_EN to average left and right.
module audio_note_detector #(
  parameter logic signed [31:0] HYST      = 32'sd4000000,
  parameter int unsigned        PER_C     = 192000,
  parameter int unsigned        PER_D     = 172000,
  parameter int unsigned        PER_E     = 152000,
  parameter int unsigned        PER_F     = 143000,
  parameter int unsigned        PER_G     = 128000,
  parameter int unsigned        PER_A     = 114000,
  parameter int unsigned        PER_B     = 102000,
  parameter int unsigned        TOL_SHIFT = 5,
  parameter int unsigned        STABLE_N  = 3,
  parameter int unsigned        TIMEOUT   = 400000
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        audio_in_available,
  input  logic [31:0] left_channel_audio_in,
  input  logic [31:0] right_channel_audio_in,
  output logic        read_audio_in,
  output logic [6:0]  note_onehot,
  output logic        note_valid,
  output logic [31:0] period_cycles
);

  localparam int unsigned SW = 32;
  localparam int unsigned NW = 7;
  localparam int unsigned MW = 4;

  typedef enum logic {BELOW, ABOVE} xing_t;

  logic signed [SW-1:0] sample_next_c;
  logic signed [SW-1:0] sample_q;
  logic                 sample_vld_q;
  logic                 pop_c;

  xing_t                xing_q;
  xing_t                xing_next_c;
  logic                 rise_c;

  logic [SW-1:0]        cnt_q;
  logic                 armed_q;
  logic [MW-1:0]        match_q;
  logic [NW-1:0]        prev_q;
  logic [NW-1:0]        hits_c;
  logic [NW-1:0]        cand_c;
  logic                 timeout_c;
  logic                 locked_c;

  // Sample source: left only, or the non-overflowing average of both channels.
`ifdef NOTE_DETECT_STEREO_EN
  logic [SW:0] sum_c;
  assign sum_c         = {left_channel_audio_in[SW-1], left_channel_audio_in}
                       + {right_channel_audio_in[SW-1], right_channel_audio_in};
  assign sample_next_c = sum_c[SW:1];
`else
  logic unused_right_c;
  assign unused_right_c = ^right_channel_audio_in;
  assign sample_next_c  = left_channel_audio_in;
`endif

  assign pop_c = audio_in_available && !read_audio_in;

  // FIFO pop strobe and sample capture; the strobe can never fire two cycles in a row.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      read_audio_in <= 1'b0;
      sample_vld_q  <= 1'b0;
      sample_q      <= '0;
    end else begin
      read_audio_in <= pop_c;
      sample_vld_q  <= pop_c;
      if (pop_c) begin
        sample_q <= sample_next_c;
      end
    end
  end

  // Crossing FSM: state register.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      xing_q <= BELOW;
    end else begin
      xing_q <= xing_next_c;
    end
  end

  // Crossing FSM: next state; samples inside the hysteresis band hold the state.
  always_comb begin
    xing_next_c = xing_q;
    if (sample_vld_q) begin
      case (xing_q)
        BELOW:   if (sample_q > HYST)  xing_next_c = ABOVE;
        ABOVE:   if (sample_q < -HYST) xing_next_c = BELOW;
        default: xing_next_c = BELOW;
      endcase
    end
  end

  // Crossing FSM: rising event output.
  always_comb begin
    rise_c = 1'b0;
    if (xing_q == BELOW && sample_vld_q && sample_q > HYST) begin
      rise_c = 1'b1;
    end
  end

  function automatic logic in_window(input logic [SW-1:0] c, input logic [SW-1:0] per);
    logic [SW-1:0] tol;
    tol = per >> TOL_SHIFT;
    return (c >= per - tol) && (c <= per + tol);
  endfunction

  assign hits_c = {in_window(cnt_q, SW'(PER_C)), in_window(cnt_q, SW'(PER_D)),
                   in_window(cnt_q, SW'(PER_E)), in_window(cnt_q, SW'(PER_F)),
                   in_window(cnt_q, SW'(PER_G)), in_window(cnt_q, SW'(PER_A)),
                   in_window(cnt_q, SW'(PER_B))};

  // Overlapping windows resolve toward the lower note (C wins).
  always_comb begin
    cand_c = '0;
    if      (hits_c[6]) cand_c = 7'b1000000;
    else if (hits_c[5]) cand_c = 7'b0100000;
    else if (hits_c[4]) cand_c = 7'b0010000;
    else if (hits_c[3]) cand_c = 7'b0001000;
    else if (hits_c[2]) cand_c = 7'b0000100;
    else if (hits_c[1]) cand_c = 7'b0000010;
    else if (hits_c[0]) cand_c = 7'b0000001;
  end

  assign timeout_c = (cnt_q == SW'(TIMEOUT));
  assign locked_c  = (match_q >= MW'(STABLE_N));

  // Period counter, arming and stability tracking; timeout forces the next edge to re-arm.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      cnt_q         <= '0;
      armed_q       <= 1'b0;
      match_q       <= '0;
      prev_q        <= '0;
      period_cycles <= '0;
    end else begin
      if (!timeout_c) begin
        cnt_q <= cnt_q + 32'd1;
      end
      if (timeout_c) begin
        match_q <= '0;
        armed_q <= 1'b0;
        if (rise_c) begin
          cnt_q   <= '0;
          armed_q <= 1'b1;
        end
      end else if (rise_c) begin
        cnt_q <= '0;
        if (!armed_q) begin
          armed_q <= 1'b1;
        end else begin
          period_cycles <= cnt_q;
          if (cand_c == '0) begin
            match_q <= '0;
          end else if (cand_c == prev_q) begin
            if (!locked_c) begin
              match_q <= match_q + 4'd1;
            end
          end else begin
            prev_q  <= cand_c;
            match_q <= 4'd1;
          end
        end
      end
    end
  end

  // Reported note follows the stability tracker one cycle later.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      note_onehot <= '0;
      note_valid  <= 1'b0;
    end else begin
      note_onehot <= locked_c ? prev_q : '0;
      note_valid  <= locked_c && (prev_q != '0);
    end
  end

endmodule

// File: tb/tb_audio_note_detector.sv
// Bench for audio_note_detector: square tones through a randomly-paced FIFO, checked against an
// event-level model of period measurement, note windows, stability and silence timeout.
module tb_audio_note_detector;

  localparam int unsigned TIMEOUT  = 2000;
  localparam int unsigned STABLE_N = 3;
  localparam int unsigned PER_TB [7] = '{960, 860, 760, 715, 640, 570, 510};
  localparam logic signed [31:0] HYST  = 32'sd4000000;
  localparam logic signed [31:0] AMP   = 32'sd100000000;
  localparam logic signed [31:0] QUIET = 32'sd1000000;
  localparam int PTOL = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        avail = 1'b0;
  logic        read;
  logic        valid;
  logic [6:0]  note;
  logic [31:0] left;
  logic [31:0] right;
  logic [31:0] period;
  logic signed [31:0] wave_val = -AMP;
  logic [31:0] noise = '0;
  logic        exp_read = 1'b0;

  int feed_mode = 0;
  int zeros = 0;
  int cyc = 0;
  int pops = 0;
  int checks = 0;
  int errors = 0;

  // Reference model state, updated once per driven rising transition.
  logic       m_armed = 1'b0;
  logic [6:0] m_prev = '0;
  int         m_match = 0;
  int         m_last = 0;
  int         m_per = 0;

  always #5 clk = ~clk;

  assign left = wave_val;
`ifdef NOTE_DETECT_STEREO_EN
  assign right = wave_val;
`else
  assign right = noise;
`endif

  audio_note_detector #(
    .HYST(HYST), .PER_C(960), .PER_D(860), .PER_E(760), .PER_F(715), .PER_G(640),
    .PER_A(570), .PER_B(510), .TOL_SHIFT(5), .STABLE_N(STABLE_N), .TIMEOUT(TIMEOUT)
  ) dut (
    .CLOCK_50(clk),
    .reset(rst),
    .audio_in_available(avail),
    .left_channel_audio_in(left),
    .right_channel_audio_in(right),
    .read_audio_in(read),
    .note_onehot(note),
    .note_valid(valid),
    .period_cycles(period)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // FIFO occupancy: random, never more than two empty cycles in a row.
  always @(negedge clk) begin
    noise = $urandom;
    case (feed_mode)
      1: begin
        if (zeros >= 2 || $urandom_range(3, 0) != 0) begin
          avail = 1'b1;
          zeros = 0;
        end else begin
          avail = 1'b0;
          zeros++;
        end
      end
      2:       avail = 1'b1;
      default: avail = 1'b0;
    endcase
  end

  always @(posedge clk or posedge rst) begin
    if (rst) exp_read <= 1'b0;
    else     exp_read <= avail && !exp_read;
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("read_strobe", 32'(read), 32'(exp_read));
      if (read) pops++;
    end
  end

  function automatic logic [6:0] note_of(input int g);
    logic [6:0] oh;
    for (int k = 0; k < 7; k++) begin
      int p;
      int t;
      p = int'(PER_TB[k]);
      t = p >> 5;
      if (g >= p - t && g <= p + t) begin
        oh = 7'b1000000;
        return oh >> k;
      end
    end
    return 7'b0;
  endfunction

  task automatic model_rise();
    int gap;
    logic [6:0] cand;
    gap = cyc - m_last;
    if (m_armed && gap > int'(TIMEOUT)) begin
      m_armed = 1'b0;
      m_match = 0;
    end
    if (!m_armed) begin
      m_armed = 1'b1;
    end else begin
      m_per = gap;
      cand = note_of(gap);
      if (cand == 7'b0) m_match = 0;
      else if (cand == m_prev) m_match = (m_match < int'(STABLE_N)) ? m_match + 1 : m_match;
      else begin
        m_prev = cand;
        m_match = 1;
      end
    end
    m_last = cyc;
  endtask

  function automatic logic [6:0] exp_note();
    if (m_armed && (cyc - m_last) > int'(TIMEOUT) + 20) return 7'b0;
    return (m_match >= int'(STABLE_N)) ? m_prev : 7'b0;
  endfunction

  task automatic check_state(input string tag);
    logic [6:0] en;
    int d;
    en = exp_note();
    check({tag, "_note"}, 32'(note), 32'(en));
    check({tag, "_valid"}, 32'(valid), 32'(en != 7'b0));
    if (m_per == 0) begin
      check({tag, "_period"}, period, 32'd0);
    end else begin
      d = int'(period) - (m_per - 1);
      check($sformatf("%s_period(got %0d nom %0d)", tag, period, m_per - 1),
            32'(d >= -PTOL && d <= PTOL), 32'd1);
    end
  endtask

  task automatic play(input int half, input int nper, input logic signed [31:0] amp, input string tag);
    for (int p = 0; p < nper; p++) begin
      @(negedge clk);
      wave_val = amp;
      if (amp > HYST) model_rise();
      repeat (half / 2) @(negedge clk);
      check_state($sformatf("%s_p%0d", tag, p));
      repeat (half - half / 2) @(negedge clk);
      wave_val = -amp;
      repeat (half - 1) @(negedge clk);
    end
  endtask

  initial begin
    int p0;
    feed_mode = 1;
    repeat (3) @(negedge clk);
    check("rst_read", 32'(read), 32'd0);
    check("rst_note", 32'(note), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_period", period, 32'd0);
    rst = 1'b0;

    // Held-high FIFO flag: strobe alternates, 20 cycles give 10 pops.
    @(posedge clk) feed_mode = 0;
    repeat (4) @(posedge clk);
    p0 = pops;
    feed_mode = 2;
    repeat (20) @(posedge clk);
    feed_mode = 0;
    repeat (4) @(posedge clk);
    check("pops_held20", 32'(pops - p0), 32'd10);
    feed_mode = 1;
    @(negedge clk);

    play(480, 6, AMP, "c_lock");
    check("c_onehot", 32'(note), 32'h40);
    play(255, 5, AMP, "b_switch");
    check("b_onehot", 32'(note), 32'h01);
    play(255, 8, QUIET, "quiet");
    check("quiet_valid", 32'(valid), 32'd0);

    // Lock E, then flat silence until the timeout clears it.
    play(380, 5, AMP, "e_lock");
    wave_val = 32'sd0;
    while (cyc < m_last + int'(TIMEOUT) - 40) @(negedge clk);
    check("e_hold_note", 32'(note), 32'h10);
    check_state("e_hold");
    while (cyc < m_last + int'(TIMEOUT) + 40) @(negedge clk);
    check("e_timeout_note", 32'(note), 32'd0);
    check_state("e_timeout");
    play(380, 5, AMP, "e_relock");
    check("e_relock_onehot", 32'(note), 32'h10);

    // Lock G, reset in the middle of a low half, then relock.
    play(320, 5, AMP, "g_lock");
    check("g_onehot", 32'(note), 32'h04);
    @(negedge clk);
    wave_val = AMP;
    model_rise();
    repeat (320) @(negedge clk);
    wave_val = -AMP;
    repeat (160) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_note", 32'(note), 32'd0);
    check("midrst_valid", 32'(valid), 32'd0);
    check("midrst_period", period, 32'd0);
    check("midrst_read", 32'(read), 32'd0);
    m_armed = 1'b0;
    m_match = 0;
    m_per = 0;
    m_prev = 7'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (156) @(negedge clk);
    play(320, 5, AMP, "g_relock");
    check("g_relock_onehot", 32'(note), 32'h04);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
